// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
// Defaults assume a 150 MHz system clock.
package button_pkg;

  localparam int unsigned CLK_FREQ_HZ               = 150_000_000;
  // 10 ms of stable samples before a level change is believed
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = CLK_FREQ_HZ / 100;
  // 1 s of continuous hold before a long press is reported
  localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = CLK_FREQ_HZ;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } button_state_t;

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer for a single asynchronous level. The reset value is a
// parameter so the flops come out of reset at the "not pressed" pad level.
module button_sync #(
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw level through two flops to settle metastability
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronizes the raw pad, requires DEBOUNCE_CYCLES
// stable samples to accept a press or release, and emits one-cycle strobes.
// Optional long-press detection is built only when BUTTON_LONG_PRESS_EN is
// defined; otherwise long_press is tied low.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The counter stops one short of DEBOUNCE_CYCLES: the sample that would
  // complete the count is the one that commits the new level.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  button_state_t   state;
  logic [DB_W-1:0] db_cnt;
  logic            sync_level;
  logic            s;

  button_sync #(
    .RESET_VALUE (ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (button),
    .q     (sync_level)
  );

  assign s = ACTIVE_LOW ? ~sync_level : sync_level;

  // Debounce FSM with registered level and press/release strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RELEASED;
      db_cnt        <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        RELEASED: begin
          if (s) begin
            state  <= DEB_PRESS;
            db_cnt <= '0;
          end
        end
        DEB_PRESS: begin
          if (!s) begin
            state  <= RELEASED;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state       <= PRESSED;
            db_cnt      <= '0;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            state  <= DEB_RELEASE;
            db_cnt <= '0;
          end
        end
        DEB_RELEASE: begin
          if (s) begin
            state  <= PRESSED;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state         <= RELEASED;
            db_cnt        <= '0;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: begin
          state  <= RELEASED;
          db_cnt <= '0;
        end
      endcase
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int LP_W = $clog2(64'(LONG_PRESS_CYCLES) + 64'd1);
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_PRESS_CYCLES);
  localparam logic [LP_W-1:0] LP_PRE = LP_W'(LONG_PRESS_CYCLES - 1);

  logic [LP_W-1:0] lp_cnt;
  logic            in_hold;
  logic            release_accept;

  assign in_hold        = (state == PRESSED) || (state == DEB_RELEASE);
  assign release_accept = (state == DEB_RELEASE) && !s && (db_cnt == DB_LAST);

  // Saturating hold-time counter; a release committed on the limit cycle wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lp_cnt     <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!in_hold) begin
        lp_cnt <= '0;
      end else if (lp_cnt != LP_MAX) begin
        lp_cnt <= lp_cnt + LP_W'(1);
        if ((lp_cnt == LP_PRE) && !release_accept) begin
          long_press <= 1'b1;
        end
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed testbench for button_debounce (DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=10, ACTIVE_LOW=1). Long-press expectations apply only when
// BUTTON_LONG_PRESS_EN is defined.
module tb_button_debounce;

`ifdef BUTTON_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic button = 1'b1;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  int vec_count  = 0;
  int miss_count = 0;

  typedef struct {
    string name;
    logic  rst;
    logic  btn;
    logic  exp_p;
    logic  exp_pp;
    logic  exp_rp;
    logic  exp_lp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (10),
    .ACTIVE_LOW        (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .button        (button),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  function automatic void add_rows(string name, int n, logic btn, logic p,
                                   logic pp, logic rp, logic lp);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.name   = name;
      v.rst    = 1'b0;
      v.btn    = btn;
      v.exp_p  = p;
      v.exp_pp = pp;
      v.exp_rp = rp;
      v.exp_lp = lp;
      vecs.push_back(v);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic btn);
    reset  = rst;
    button = btn;
  endtask

  task automatic checkOutput(input string name, input logic p, input logic pp,
                             input logic rp, input logic lp);
    logic [3:0] act;
    logic [3:0] exp;
    act = {pressed, press_pulse, release_pulse, long_press};
    exp = {p, pp, rp, lp & LP_EN};
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: {pressed,press_pulse,release_pulse,long_press} got %b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic runCycles(input string name, input int n, input logic p,
                           input logic pp, input logic rp, input logic lp);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput(name, p, pp, rp, lp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Asynchronous reset must clear outputs with no clock edge
    applyStimulus(1'b0, 1'b1);
    #2;
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("resetState", 1'b0, 1'b0, 1'b0, 1'b0);
    runCycles("inReset", 2, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);

    // Clean press, 50-cycle hold, clean release (row cN = cycle N of the press)
    add_rows("idle",         2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_rows("cleanDeb",     7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_rows("cleanPress",   1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add_rows("cleanHold",    9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_rows("longPress",    1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add_rows("cleanHold2",   39, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_rows("relStart",     1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_rows("relDeb",       6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_rows("cleanRelease", 1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    add_rows("idleAfter",    3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Bounce on press: low 2, high 1, low held; release before long press
    add_rows("bounceLow",    2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_rows("bounceHigh",   1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_rows("bounceDeb",    7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_rows("bouncePress",  1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add_rows("bounceHold",   1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_rows("bounceRelDeb", 7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_rows("bounceRel",    1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    add_rows("bounceIdle",   3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // One-cycle release glitch while held; long press still counts through it
    add_rows("glitchDeb",    7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_rows("glitchPress",  1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add_rows("glitchHold",   1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_rows("glitchHigh",   1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_rows("glitchHold2",  4,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_rows("glitchRelDeb", 3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_rows("glitchLong",   1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    add_rows("glitchRelDeb2",3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_rows("glitchRel",    1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    add_rows("glitchIdle",   3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      tick();
      checkOutput(vecs[i].name, vecs[i].exp_p, vecs[i].exp_pp,
                  vecs[i].exp_rp, vecs[i].exp_lp);
      applyStimulus(vecs[i].rst, vecs[i].btn);
    end

    // Release committed on the exact cycle the long-press count hits 10
    runCycles("limitIdle", 2, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    runCycles("limitDeb",    6, 1'b0, 1'b0, 1'b0, 1'b0);
    runCycles("limitPress",  1, 1'b1, 1'b1, 1'b0, 1'b0);
    runCycles("limitHold",   3, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    runCycles("limitRelDeb", 6, 1'b1, 1'b0, 1'b0, 1'b0);
    runCycles("limitRel",    1, 1'b0, 1'b0, 1'b1, 1'b0);
    runCycles("limitAfter",  3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while held: no release strobe, then a fresh press after reset
    applyStimulus(1'b0, 1'b0);
    runCycles("midDeb",   6, 1'b0, 1'b0, 1'b0, 1'b0);
    runCycles("midPress", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    runCycles("midHold",  3, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    #1;
    checkOutput("resetMidPress", 1'b0, 1'b0, 1'b0, 1'b0);
    runCycles("heldInReset", 2, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    runCycles("postResetDeb",   6, 1'b0, 1'b0, 1'b0, 1'b0);
    runCycles("postResetPress", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    runCycles("postResetHold",  2, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    runCycles("postResetRelDeb", 6, 1'b1, 1'b0, 1'b0, 1'b0);
    runCycles("postResetRel",    1, 1'b0, 1'b0, 1'b1, 1'b0);
    runCycles("postResetIdle",   2, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
